// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 4-stage CPU: opcodes, ALU operand selects
// and the control FSM state type.
package cpu_pkg;

    localparam logic [3:0] OP_MV   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_CMP  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_MVHI = 4'h6;
    localparam logic [3:0] OP_JR   = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JN   = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hC;

    localparam logic [2:0] SEL_A_RX    = 3'd0;
    localparam logic [2:0] SEL_A_RY    = 3'd1;
    localparam logic [2:0] SEL_A_PC    = 3'd2;
    localparam logic [2:0] SEL_A_IMM   = 3'd3;
    localparam logic [2:0] SEL_A_IMMHI = 3'd4;

    localparam logic [2:0] SEL_B_RY    = 3'd0;
    localparam logic [2:0] SEL_B_IMM   = 3'd1;
    localparam logic [2:0] SEL_B_OFFS  = 3'd2;
    localparam logic [2:0] SEL_B_ZERO  = 3'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode-to-control map; one copy serves the execute stage and
// another the write stage, each consuming only the outputs relevant to it.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [4:0] i_opcode,
    input  logic       i_en,
    input  logic       i_n,
    input  logic       i_z,
    output logic [2:0] o_sel_a,
    output logic [2:0] o_sel_b,
    output logic       o_addsub,
    output logic       o_ldnz,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic       o_ldr,
    output logic       o_ld_mem_rd,
    output logic       o_taken,
    output logic       o_ldpc_7
);
    logic [3:0] w_op;
    logic       w_imm;

    assign w_op  = i_opcode[3:0];
    assign w_imm = i_opcode[4];

    always_comb begin
        o_sel_a     = 3'd0;
        o_sel_b     = 3'd0;
        o_addsub    = 1'b0;
        o_ldnz      = 1'b0;
        o_mem_rd    = 1'b0;
        o_mem_wr    = 1'b0;
        o_ldr       = 1'b0;
        o_ld_mem_rd = 1'b0;
        o_taken     = 1'b0;
        o_ldpc_7    = 1'b0;
        if (i_en) begin
            case (w_op)
                OP_MV: begin
                    o_sel_a = w_imm ? SEL_A_IMM : SEL_A_RY;
                    o_sel_b = SEL_B_ZERO;
                    o_ldr   = 1'b1;
                end
                OP_ADD, OP_SUB, OP_CMP: begin
                    o_sel_a  = SEL_A_RX;
                    o_sel_b  = w_imm ? SEL_B_IMM : SEL_B_RY;
                    o_ldnz   = 1'b1;
                    o_addsub = (w_op != OP_ADD);
                    o_ldr    = (w_op != OP_CMP);
                end
                // ld/st have no immediate form; those codes fall through as NOPs
                OP_LD: begin
                    if (!w_imm) begin
                        o_mem_rd    = 1'b1;
                        o_ldr       = 1'b1;
                        o_ld_mem_rd = 1'b1;
                    end
                end
                OP_ST: begin
                    if (!w_imm) o_mem_wr = 1'b1;
                end
                OP_MVHI: begin
                    o_sel_a = SEL_A_IMMHI;
                    o_sel_b = SEL_B_ZERO;
                    o_ldr   = 1'b1;
                end
                OP_JR, OP_JZ, OP_JN, OP_CALL: begin
                    o_sel_a  = w_imm ? SEL_A_PC : SEL_A_RY;
                    o_sel_b  = w_imm ? SEL_B_OFFS : SEL_B_ZERO;
                    o_taken  = (w_op == OP_JR) || (w_op == OP_CALL) ||
                               ((w_op == OP_JZ) && i_z) ||
                               ((w_op == OP_JN) && i_n);
                    o_ldpc_7 = (w_op == OP_CALL);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_control.sv
// Pipeline control for the 4-stage CPU: stage decode, jump resolution in the
// write stage with a timed squash window, and retire/flush counters.
//   state    | meaning
//   ST_RUN   | normal issue; a taken jump squashes read/execute this cycle
//   ST_FLUSH | discarding wrong-path fetch data for FLUSH_CYCLES cycles
module cpu_control
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       read_opcode,
    input  logic [4:0]       execute_opcode,
    input  logic             n,
    input  logic             z,
    input  logic             fetch_v,
    input  logic             read_v,
    input  logic             execute_v,
    input  logic             write_v,
    output logic             ctrl_fetch_v,
    output logic             ctrl_read_v,
    output logic             ctrl_execute_v,
    output logic             ctrl_write_v,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ld_mem_rd,
    output logic [2:0]       sel_a,
    output logic [2:0]       sel_b,
    output logic             addsub,
    output logic             ldnz,
    output logic             ldpc,
    output logic             ldpc_7,
    output logic             ldr,
    output logic [CNT_W-1:0] o_retired,
    output logic [CNT_W-1:0] o_flushes
);
    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    ctrl_state_t     r_state, w_state_nxt;
    logic [FC_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_retired, r_flushes;

    logic w_squash, w_taken, w_ex_en, w_wr_en;

    logic [2:0] w_wr_sel_a, w_wr_sel_b;
    logic w_wr_addsub, w_wr_ldnz, w_wr_mem_rd, w_wr_mem_wr;
    logic w_ex_ldr, w_ex_ld_mem_rd, w_ex_taken, w_ex_ldpc_7;

    assign w_wr_en = write_v & ~reset;
    assign w_ex_en = read_v & ~reset & ~w_squash;

    cpu_decode u_dec_ex (
        .i_opcode    (read_opcode),
        .i_en        (w_ex_en),
        .i_n         (1'b0),
        .i_z         (1'b0),
        .o_sel_a     (sel_a),
        .o_sel_b     (sel_b),
        .o_addsub    (addsub),
        .o_ldnz      (ldnz),
        .o_mem_rd    (mem_rd),
        .o_mem_wr    (mem_wr),
        .o_ldr       (w_ex_ldr),
        .o_ld_mem_rd (w_ex_ld_mem_rd),
        .o_taken     (w_ex_taken),
        .o_ldpc_7    (w_ex_ldpc_7)
    );

    cpu_decode u_dec_wr (
        .i_opcode    (execute_opcode),
        .i_en        (w_wr_en),
        .i_n         (n),
        .i_z         (z),
        .o_sel_a     (w_wr_sel_a),
        .o_sel_b     (w_wr_sel_b),
        .o_addsub    (w_wr_addsub),
        .o_ldnz      (w_wr_ldnz),
        .o_mem_rd    (w_wr_mem_rd),
        .o_mem_wr    (w_wr_mem_wr),
        .o_ldr       (ldr),
        .o_ld_mem_rd (ld_mem_rd),
        .o_taken     (w_taken),
        .o_ldpc_7    (ldpc_7)
    );

    // Stage valids from the datapath and the cross-stage decode halves are not needed here
    logic w_unused;
    assign w_unused = ^{fetch_v, execute_v, w_wr_sel_a, w_wr_sel_b, w_wr_addsub,
                        w_wr_ldnz, w_wr_mem_rd, w_wr_mem_wr, w_ex_ldr,
                        w_ex_ld_mem_rd, w_ex_taken, w_ex_ldpc_7};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_squash    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_taken) begin
                    w_squash = 1'b1;
                    if (FLUSH_CYCLES > 0) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = FC_W'(FLUSH_CYCLES);
                    end
                end
            end
            ST_FLUSH: begin
                w_squash = 1'b1;
                if (r_cnt == FC_W'(1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - FC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_retired <= '0;
            r_flushes <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (write_v) r_retired <= r_retired + CNT_W'(1);
            if (w_taken) r_flushes <= r_flushes + CNT_W'(1);
        end
    end

    assign ctrl_fetch_v   = ~reset;
    assign ctrl_write_v   = ~reset;
    assign ctrl_read_v    = ~reset & ~w_squash;
    assign ctrl_execute_v = ~reset & ~w_squash;
    assign ldpc           = w_taken;
    assign o_retired      = r_retired;
    assign o_flushes      = r_flushes;

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: directed checks plus randomized traffic
// compared every cycle against an instruction-level reference model.
module tb_cpu_control;

    localparam int FLUSH_CYCLES = 1;

    logic        clk;
    logic        reset;
    logic [4:0]  read_opcode, execute_opcode;
    logic        n, z, fetch_v, read_v, execute_v, write_v;
    logic        ctrl_fetch_v, ctrl_read_v, ctrl_execute_v, ctrl_write_v;
    logic        mem_rd, mem_wr, ld_mem_rd, addsub, ldnz, ldpc, ldpc_7, ldr;
    logic [2:0]  sel_a, sel_b;
    logic [15:0] o_retired, o_flushes;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    int          m_left = 0;
    logic [15:0] m_ret  = '0;
    logic [15:0] m_fl   = '0;

    cpu_control #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .read_opcode    (read_opcode),
        .execute_opcode (execute_opcode),
        .n              (n),
        .z              (z),
        .fetch_v        (fetch_v),
        .read_v         (read_v),
        .execute_v      (execute_v),
        .write_v        (write_v),
        .ctrl_fetch_v   (ctrl_fetch_v),
        .ctrl_read_v    (ctrl_read_v),
        .ctrl_execute_v (ctrl_execute_v),
        .ctrl_write_v   (ctrl_write_v),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .ld_mem_rd      (ld_mem_rd),
        .sel_a          (sel_a),
        .sel_b          (sel_b),
        .addsub         (addsub),
        .ldnz           (ldnz),
        .ldpc           (ldpc),
        .ldpc_7         (ldpc_7),
        .ldr            (ldr),
        .o_retired      (o_retired),
        .o_flushes      (o_flushes)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected execute-stage controls as a packed word {sel_a, sel_b, addsub, ldnz, mem_rd, mem_wr}
    function automatic logic [9:0] model_ex(input logic [4:0] code);
        int k;
        bit imm;
        logic [2:0] a, b;
        bit sub, nz, rd, wr;
        k = int'(code[3:0]);
        imm = code[4];
        a = 0; b = 0; sub = 0; nz = 0; rd = 0; wr = 0;
        if (k == 0) begin a = imm ? 3 : 1; b = 3; end
        if (k >= 1 && k <= 3) begin a = 0; b = imm ? 1 : 0; nz = 1; sub = (k >= 2); end
        if (k == 6) begin a = 4; b = 3; end
        if (k == 8 || k == 9 || k == 10 || k == 12) begin
            a = imm ? 2 : 1;
            b = imm ? 2 : 3;
        end
        rd = (code == 5'h04);
        wr = (code == 5'h05);
        return {a, b, sub, nz, rd, wr};
    endfunction

    function automatic bit model_taken(input logic [4:0] code, input logic fz, input logic fn);
        int k;
        k = int'(code[3:0]);
        return (k == 8) || (k == 12) || (k == 9 && fz) || (k == 10 && fn);
    endfunction

    function automatic bit model_ldr(input logic [4:0] code);
        int k;
        k = int'(code[3:0]);
        return (k == 0) || (k == 1) || (k == 2) || (k == 6) || (code == 5'h04);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_left <= 0;
            m_ret  <= '0;
            m_fl   <= '0;
        end else begin
            if (m_left > 0) m_left <= m_left - 1;
            else if (write_v && model_taken(execute_opcode, z, n)) m_left <= FLUSH_CYCLES;
            if (write_v) m_ret <= m_ret + 16'd1;
            if (write_v && model_taken(execute_opcode, z, n)) m_fl <= m_fl + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit tk, sq, ex_on, wr_on;
            logic [9:0] ex;
            wr_on = !reset && write_v;
            tk    = wr_on && model_taken(execute_opcode, z, n);
            sq    = !reset && (m_left > 0 || tk);
            ex_on = !reset && read_v && !sq;
            ex    = ex_on ? model_ex(read_opcode) : 10'd0;
            chk("ctrl_fetch_v", ctrl_fetch_v, !reset);
            chk("ctrl_write_v", ctrl_write_v, !reset);
            chk("ctrl_read_v", ctrl_read_v, !reset && !sq);
            chk("ctrl_execute_v", ctrl_execute_v, !reset && !sq);
            chk("ex_ctrl", {sel_a, sel_b, addsub, ldnz, mem_rd, mem_wr}, ex);
            chk("ldpc", ldpc, tk);
            chk("ldpc_7", ldpc_7, wr_on && execute_opcode[3:0] == 4'hC);
            chk("ldr", ldr, wr_on && model_ldr(execute_opcode));
            chk("ld_mem_rd", ld_mem_rd, wr_on && execute_opcode == 5'h04);
            chk("o_retired", o_retired, m_ret);
            chk("o_flushes", o_flushes, m_fl);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1; read_opcode = 5'h01; execute_opcode = 5'h08;
        n = 0; z = 0; fetch_v = 1; read_v = 1; execute_v = 1; write_v = 1;
        mid();
        chk("rst_fetch_v", ctrl_fetch_v, 0);
        chk("rst_ldpc", ldpc, 0);
        chk("rst_ldnz", ldnz, 0);
        step();
        chk_en = 1;
        mid();
        chk("rst_write_v", ctrl_write_v, 0);
        chk("rst_retired", o_retired, 0);
        step();

        reset = 0; read_v = 0; write_v = 0;
        mid();
        chk("post_fetch_v", ctrl_fetch_v, 1);
        chk("post_read_v", ctrl_read_v, 1);
        chk("post_flushes", o_flushes, 0);
        step();

        read_v = 1; read_opcode = 5'h11;
        mid();
        chk("addi_sel_a", sel_a, 0);
        chk("addi_sel_b", sel_b, 1);
        chk("addi_addsub", addsub, 0);
        chk("addi_ldnz", ldnz, 1);
        step();
        read_opcode = 5'h03;
        mid();
        chk("cmp_addsub", addsub, 1);
        chk("cmp_ldnz", ldnz, 1);
        chk("cmp_sel_b", sel_b, 0);
        step();

        read_v = 0; write_v = 1; execute_opcode = 5'h04;
        mid();
        chk("ld_ldr", ldr, 1);
        chk("ld_mem_sel", ld_mem_rd, 1);
        step();
        write_v = 0;
        mid();
        chk("ld_nov_ldr", ldr, 0);
        step();

        read_v = 1; read_opcode = 5'h01; write_v = 1; execute_opcode = 5'h09; z = 1;
        mid();
        chk("jz_ldpc", ldpc, 1);
        chk("jz_read_v", ctrl_read_v, 0);
        chk("jz_exec_v", ctrl_execute_v, 0);
        chk("jz_flushes0", o_flushes, 0);
        step();
        write_v = 0;
        mid();
        chk("jz_read_v2", ctrl_read_v, 0);
        chk("jz_exec_v2", ctrl_execute_v, 0);
        chk("jz_flushes1", o_flushes, 1);
        step();
        mid();
        chk("jz_release", ctrl_read_v, 1);
        step();

        write_v = 1; z = 0;
        mid();
        chk("jz_nt_ldpc", ldpc, 0);
        chk("jz_nt_read_v", ctrl_read_v, 1);
        step();

        execute_opcode = 5'h0C;
        mid();
        chk("call_ldpc", ldpc, 1);
        chk("call_ldpc_7", ldpc_7, 1);
        chk("call_exec_v", ctrl_execute_v, 0);
        step();
        write_v = 0; reset = 1;
        mid();
        chk("flush_rst_read_v", ctrl_read_v, 0);
        step();
        reset = 0;
        mid();
        chk("flush_rst_rel_read", ctrl_read_v, 1);
        chk("flush_rst_rel_exec", ctrl_execute_v, 1);
        chk("flush_rst_fl", o_flushes, 0);
        step();

        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 63) == 0);
            read_v         = ($urandom_range(0, 3) != 0);
            read_opcode    = 5'($urandom);
            execute_opcode = 5'($urandom);
            n              = 1'($urandom);
            z              = 1'($urandom);
            fetch_v        = 1'($urandom);
            execute_v      = 1'($urandom);
            write_v        = (m_left == 0) && ($urandom_range(0, 3) != 0);
            step();
        end

        reset = 1;
        step();
        reset = 0; write_v = 1; execute_opcode = 5'h00; read_v = 0;
        repeat (70000) step();
        write_v = 0;
        mid();
        chk("retired_wrap", o_retired, 16'd4464);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Pipeline control unit for the 16-bit 4-stage CPU (fetch / RF read / execute / write).
- Decodes opcodes presented by cpu_datapath and drives all datapath control inputs.
- Resolves jumps in the write stage and squashes wrong-path instructions via a registered flush state.
- Keeps retire and flush performance counters; sits beside cpu_datapath inside the cpu top.

Parameters:
- FLUSH_CYCLES, 1, extra cycles after a taken jump during which fetched data is discarded (instruction-memory read latency).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- read_opcode  in  5  opcode of the instruction in the execute stage (datapath read-stage register)
- execute_opcode  in  5  opcode of the instruction in the write stage
- n, z  in  1 each  datapath flags
- fetch_v, read_v, execute_v, write_v  in  1 each  datapath stage-valid bits
- ctrl_fetch_v, ctrl_read_v, ctrl_execute_v, ctrl_write_v  out  1 each  stage enables
- mem_rd, mem_wr  out  1 each  execute-stage memory access
- ld_mem_rd  out  1  write-stage select of load data
- sel_a, sel_b  out  3 each  ALU operand selects
- addsub, ldnz  out  1 each  ALU subtract; flag load
- ldpc, ldpc_7, ldr  out  1 each  PC load; R7 <= link PC; register write
- o_retired  out  CNT_W  instructions completed
- o_flushes  out  CNT_W  taken jumps

Behaviour:
- Opcode bits [3:0]: mv 0, add 1, sub 2, cmp 3, ld 4, st 5, mvhi 6, jr 8, jz 9, jn 10, call 12. Bit 4 selects the immediate form.
- Valid for imm: mv, add, sub, cmp, mvhi, jr, jz, jn, call. Any other code is a NOP: no writes, no flags, no jump.
- Execute-stage decode is combinational on read_opcode, active only when read_v=1 and not squashing; otherwise everything is 0.
- Register-form selects: mv a=1, b=3. add/sub/cmp a=0, b=0. cmp addsub=1.
- Immediate-form selects: mv a=3, b=3. add/sub/cmp a=0, b=1. mvhi a=4, b=3.
- Jump targets: register jump a=1, b=3. Immediate jump a=2, b=2.
- ldnz=1 for add, sub, cmp. addsub=1 for sub and cmp.
- ld: mem_rd=1. st: mem_wr=1.
- Write-stage decode is combinational on execute_opcode, active only when write_v=1.
- ldr=1 for mv, add, sub, mvhi, ld. ld_mem_rd=1 for ld.
- Taken jump: jr, or call, or jz with z=1, or jn with n=1. Taken drives ldpc=1. ldpc_7=1 for call regardless of being taken.
- FSM states: RUN, FLUSH.
  - RUN: a taken jump in cycle T forces ctrl_read_v=0 and ctrl_execute_v=0 in T. Load cnt=FLUSH_CYCLES and go to FLUSH if FLUSH_CYCLES>0; else stay in RUN.
  - FLUSH: ctrl_read_v=0 and ctrl_execute_v=0. Decrement cnt; return to RUN when cnt reaches 1.
- ctrl_fetch_v=1 always after reset. ctrl_write_v=1 except in the reset cycle.
- A taken jump cannot occur in FLUSH, because squashed instructions never reach write.
- Counters: o_retired increments when write_v=1; o_flushes increments on each taken jump. Both wrap modulo 2^CNT_W.
- Reset: state=RUN, cnt=0, counters=0. In the reset cycle, ctrl_*_v=0 and all decode outputs are 0.
- Reset asserted during FLUSH returns to RUN on the next edge.

Decomposition:
- Package cpu_pkg: opcode localparams, sel_a/sel_b encodings, and the state enum typedef. cpu_datapath imports it too.
- One natural sub-module, cpu_decode: purely combinational opcode-to-control map, instantiated twice (execute-stage set, write-stage set).
- FSM and counters live in cpu_control.

Test Plan:
- Reset held 2 cycles, then released → all decode outputs 0 during reset; ctrl_fetch_v=1 from the first cycle after release; counters=0.
- read_opcode=5'h11, read_v=1 → sel_a=0, sel_b=1, addsub=0, ldnz=1. read_opcode=5'h03 → addsub=1, ldnz=1, sel_b=0.
- execute_opcode=5'h04, write_v=1 → ldr=1, ld_mem_rd=1. Same with write_v=0 → ldr=0.
- execute_opcode=5'h09, write_v=1: z=1 → ldpc=1; ctrl_read_v and ctrl_execute_v low in that cycle and the next (FLUSH_CYCLES=1); o_flushes 0→1. z=0 → ldpc=0, no squash.
- execute_opcode=5'h0C, write_v=1 → ldpc=1, ldpc_7=1, flush sequence. Reset asserted during FLUSH → RUN next cycle, squash released.
- 70000 consecutive write_v=1 cycles → o_retired wraps to 70000 mod 65536 = 4464.
